hive_reg_i2s_tx: RTL

rbus register peripheral that takes stereo PCM frames written by hive_core and serializes them to an external I2S DAC. It sits downstream of the core on the same rbus as the other hive_reg_* peripherals. Its read data is ORed into rbus_rd_data at top level. A small frame FIFO decouples software write timing from the fixed-rate serializer.

---
 rtl/hive_pkg.sv | 28 ++
 rtl/hive_i2s_fifo.sv | 74 +++++++
 rtl/hive_reg_i2s_tx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/hive_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hive_pkg: shared register offsets and STAT/CTRL bit positions    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package hive_pkg;

    localparam int I2S_CTRL  = 0;
    localparam int I2S_LEFT  = 1;
    localparam int I2S_RIGHT = 2;
    localparam int I2S_STAT  = 3;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_FLUSH_BIT    = 1;
    localparam int STAT_EMPTY_BIT    = 8;
    localparam int STAT_FULL_BIT     = 9;
    localparam int STAT_UNDERRUN_BIT = 16;
    localparam int STAT_OVERFLOW_BIT = 17;

    localparam int I2S_SLOT_W = 32;

    typedef enum logic [0:0] {
        SER_IDLE = 1'b0,
        SER_RUN  = 1'b1
    } ser_state_t;

endpackage
`default_nettype wire

// File: rtl/hive_i2s_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hive_i2s_fifo: synchronous stereo-frame FIFO with flush          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hive_i2s_fifo #(
    parameter int WIDTH  = 48,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic [ADDR_W:0]   level_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              push_ok, pop_ok;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == (ADDR_W+1)'(DEPTH));
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/hive_reg_i2s_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hive_reg_i2s_tx: rbus register peripheral driving an I2S DAC     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module hive_reg_i2s_tx
    import hive_pkg::*;
#(
    parameter int ALU_W       = 32,
    parameter int RBUS_ADDR_W = 8,
    parameter int REG_BASE    = 'h30,
    parameter int SAMP_W      = 24,
    parameter int FIFO_ADDR_W = 3,
    parameter int BCLK_DIV    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
    input  logic                   rbus_wr_i,
    input  logic                   rbus_rd_i,
    input  logic [ALU_W-1:0]       rbus_wr_data_i,
    output logic [ALU_W-1:0]       rbus_rd_data_o,
    output logic                   i2s_bclk_o,
    output logic                   i2s_lrck_o,
    output logic                   i2s_sdo_o
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BCLK_DIV - 1);
    localparam int PAD_W = I2S_SLOT_W - SAMP_W;
    localparam logic [RBUS_ADDR_W-1:0] ADDR_CTRL  = RBUS_ADDR_W'(REG_BASE + I2S_CTRL);
    localparam logic [RBUS_ADDR_W-1:0] ADDR_LEFT  = RBUS_ADDR_W'(REG_BASE + I2S_LEFT);
    localparam logic [RBUS_ADDR_W-1:0] ADDR_RIGHT = RBUS_ADDR_W'(REG_BASE + I2S_RIGHT);
    localparam logic [RBUS_ADDR_W-1:0] ADDR_STAT  = RBUS_ADDR_W'(REG_BASE + I2S_STAT);

    ser_state_t            state_q, state_d;
    logic                  start_q, start_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic [5:0]            n_q, n_d;
    logic                  sdo_q, sdo_d;
    logic [63:0]           word_q, word_d;
    logic [SAMP_W-1:0]     l_q;
    logic                  underrun_q, overflow_q;
    logic [ALU_W-1:0]      rd_data_q, rd_data_d, stat_word;

    logic                  wr_ctrl, wr_left, wr_right, rd_stat, flush, en_next, load;
    logic [2*SAMP_W-1:0]   fifo_rd_data;
    logic [SAMP_W-1:0]     fifo_l, fifo_r;
    logic [FIFO_ADDR_W:0]  fifo_level;
    logic                  fifo_empty, fifo_full;
    logic [63:0]           load_word;
    logic                  unused_wr_bits;

    assign wr_ctrl  = rbus_wr_i && (rbus_addr_i == ADDR_CTRL);
    assign wr_left  = rbus_wr_i && (rbus_addr_i == ADDR_LEFT);
    assign wr_right = rbus_wr_i && (rbus_addr_i == ADDR_RIGHT);
    assign rd_stat  = rbus_rd_i && (rbus_addr_i == ADDR_STAT);
    assign flush    = wr_ctrl && rbus_wr_data_i[CTRL_FLUSH_BIT];
    assign en_next  = wr_ctrl ? rbus_wr_data_i[CTRL_EN_BIT] : (state_q == SER_RUN);
    assign unused_wr_bits = ^rbus_wr_data_i;

    hive_i2s_fifo #(
        .WIDTH  (2*SAMP_W),
        .ADDR_W (FIFO_ADDR_W)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .push_i    (wr_right),
        .pop_i     (load),
        .flush_i   (flush),
        .wr_data_i ({l_q, rbus_wr_data_i[SAMP_W-1:0]}),
        .rd_data_o (fifo_rd_data),
        .level_o   (fifo_level),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // Each sample is left-justified in its 32-bit slot; an empty FIFO sends silence.
    assign {fifo_l, fifo_r} = fifo_rd_data;
    assign load_word = fifo_empty ? 64'd0
                     : {I2S_SLOT_W'(fifo_l) << PAD_W, I2S_SLOT_W'(fifo_r) << PAD_W};

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        div_d   = div_q;
        bclk_d  = bclk_q;
        n_d     = n_q;
        sdo_d   = sdo_q;
        word_d  = word_q;
        load    = 1'b0;
        case (state_q)
            SER_IDLE: begin
                div_d  = '0;
                bclk_d = 1'b0;
                n_d    = '0;
                sdo_d  = 1'b0;
                word_d = '0;
                if (en_next) begin
                    state_d = SER_RUN;
                    start_d = 1'b1;
                end
            end
            SER_RUN: begin
                if (!en_next) begin
                    state_d = SER_IDLE;
                    div_d   = '0;
                    bclk_d  = 1'b0;
                    n_d     = '0;
                    sdo_d   = 1'b0;
                    word_d  = '0;
                end else begin
                    if (div_q == DIV_TC) begin
                        div_d  = '0;
                        bclk_d = ~bclk_q;
                        // Falling edge: the one-bit I2S delay falls out of shifting after output.
                        if (bclk_q) begin
                            n_d    = n_q + 6'd1;
                            sdo_d  = word_q[63];
                            word_d = {word_q[62:0], 1'b0};
                            if (n_q == 6'd63) begin
                                load   = 1'b1;
                                word_d = load_word;
                            end
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                    if (start_q) begin
                        load   = 1'b1;
                        word_d = load_word;
                    end
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        stat_word = '0;
        stat_word[FIFO_ADDR_W:0]     = fifo_level;
        stat_word[STAT_EMPTY_BIT]    = fifo_empty;
        stat_word[STAT_FULL_BIT]     = fifo_full;
        stat_word[STAT_UNDERRUN_BIT] = underrun_q;
        stat_word[STAT_OVERFLOW_BIT] = overflow_q;
        rd_data_d = '0;
        if (rbus_rd_i) begin
            if (rbus_addr_i == ADDR_CTRL)
                rd_data_d[CTRL_EN_BIT] = (state_q == SER_RUN);
            else if (rbus_addr_i == ADDR_STAT)
                rd_data_d = stat_word;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= SER_IDLE;
            start_q    <= 1'b0;
            div_q      <= '0;
            bclk_q     <= 1'b0;
            n_q        <= '0;
            sdo_q      <= 1'b0;
            word_q     <= '0;
            l_q        <= '0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            n_q        <= n_d;
            sdo_q      <= sdo_d;
            word_q     <= word_d;
            rd_data_q  <= rd_data_d;
            if (wr_left) l_q <= rbus_wr_data_i[SAMP_W-1:0];
            // A new event in the cycle of a STAT read survives the clear.
            underrun_q <= (load && fifo_empty) || (underrun_q && !rd_stat);
            overflow_q <= (wr_right && fifo_full) || (overflow_q && !rd_stat);
        end
    end

    assign rbus_rd_data_o = rd_data_q;
    assign i2s_bclk_o     = bclk_q;
    assign i2s_lrck_o     = n_q[5];
    assign i2s_sdo_o      = sdo_q;

endmodule
`default_nettype wire
